alu181_wide_serial: RTL and testbench

- Parametrised, slice-serial successor to the team's 4-bit 74181-style ALU.
- Executes the full 74181 function set (16 logic and 16 arithmetic functions) on WIDTH-bit operands, one SLICE-bit slice per clock, LSB slice first.
- A registered carry links the slices, so one small slice datapath serves any width.
- Adds valid/ready handshakes on input and output, plus result flags (carry, zero, signed overflow); sits between the operand issue logic and the writeback stage.

---
 rtl/alu181_wide_serial.sv | 143 ++++++++++++++
 tb/tb_alu181_wide_serial.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu181_wide_serial.sv
// Slice-serial 74181-style ALU: WIDTH-bit operands, SLICE bits per clock.
// Valid/ready on both sides; result and flags update only on entry to DONE.
module alu181_wide_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout_n,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] shadow;
  logic [3:0]       s_r;
  logic             m_r;
  logic             cy;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] a_lo;
  logic [SLICE-1:0] b_lo;
  logic [SLICE-1:0] xs;
  logic [SLICE-1:0] ys;
  logic [SLICE-1:0] fs;
  logic [SLICE:0]   sum;
  logic             c_msb;
  logic             last;
  logic             accept;

  logic [WIDTH+SLICE-1:0] cat;
  logic [WIDTH-1:0]       shadow_nx;

  // Operands shift right each RUN cycle, so the active slice is always the low one
  assign a_lo = a_r[SLICE-1:0];
  assign b_lo = b_r[SLICE-1:0];

  always_comb begin
    xs = a_lo
       | (b_lo & {SLICE{s_r[0]}})
       | (~b_lo & {SLICE{s_r[1]}});
    ys = (a_lo & ~b_lo & {SLICE{s_r[2]}})
       | (a_lo & b_lo & {SLICE{s_r[3]}});
    sum = {1'b0, xs} + {1'b0, ys}
        + {{SLICE{1'b0}}, cy};
    c_msb = xs[SLICE-1] ^ ys[SLICE-1]
          ^ sum[SLICE-1];
    fs = m_r ? ~(xs ^ ys) : sum[SLICE-1:0];
    cat = {fs, shadow};
    shadow_nx = cat[WIDTH+SLICE-1:SLICE];
  end

  assign last   = (idx == LAST_IDX);
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      m_r    <= 1'b0;
      cy     <= 1'b0;
      idx    <= '0;
      shadow <= '0;
      y      <= '0;
      cout_n <= 1'b1;
      zero   <= 1'b1;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      s_r <= s;
      m_r <= m;
      cy  <= ~cn;
      idx <= '0;
    end else if (state == RUN) begin
      a_r    <= a_r >> SLICE;
      b_r    <= b_r >> SLICE;
      shadow <= shadow_nx;
      cy     <= sum[SLICE];
      idx    <= idx + 1'b1;
      if (last) begin
        y      <= shadow_nx;
        zero   <= (shadow_nx == '0);
        cout_n <= m_r ? 1'b1 : ~sum[SLICE];
        ovf    <= m_r ? 1'b0 : (c_msb ^ sum[SLICE]);
      end
    end
  end

endmodule

// File: tb/tb_alu181_wide_serial.sv
// Directed bench for alu181_wide_serial at WIDTH=16, SLICE=4.
// Expected values are hand-computed 74181 results.
module tb_alu181_wide_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  s;
  logic        m;
  logic        cn;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        cout_n;
  logic        zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  alu181_wide_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .m         (m),
    .cn        (cn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout_n    (cout_n),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] fs,
                       input logic fm, input logic fcn,
                       input logic [15:0] fa,
                       input logic [15:0] fb);
    s = fs; m = fm; cn = fcn; a = fa; b = fb;
    in_valid = 1'b1;
  endtask

  task automatic wait_res(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
  endtask

  task automatic check_res(input string tag,
                           input logic [15:0] ey,
                           input logic ec, input logic ez,
                           input logic eo);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_cout_n"}, cout_n, ec);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] fs,
                        input logic fm, input logic fcn,
                        input logic [15:0] fa,
                        input logic [15:0] fb,
                        input logic [15:0] ey,
                        input logic ec, input logic ez,
                        input logic eo);
    chk({tag, "_in_ready"}, in_ready, 1);
    issue(fs, fm, fcn, fa, fb);
    tick();
    in_valid = 1'b0;
    a = 16'hxxxx;
    b = 16'hxxxx;
    wait_res(tag);
    check_res(tag, ey, ec, ez, eo);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s = 4'h0; m = 1'b0; cn = 1'b1;
    a = 16'h0; b = 16'h0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    check_res("rst", 16'h0000, 1, 1, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    run_op("add", 4'b1001, 0, 1, 16'h1234, 16'h4321,
           16'h5555, 1, 0, 0);
    run_op("addc", 4'b1001, 0, 1, 16'hFFFF, 16'h0001,
           16'h0000, 0, 1, 0);
    run_op("addv", 4'b1001, 0, 1, 16'h7FFF, 16'h0001,
           16'h8000, 1, 0, 1);
    run_op("subn", 4'b0110, 0, 0, 16'h0005, 16'h0007,
           16'hFFFE, 1, 0, 0);
    run_op("subp", 4'b0110, 0, 0, 16'h0007, 16'h0005,
           16'h0002, 0, 0, 0);
    run_op("xor", 4'b0110, 1, 0, 16'hF0F0, 16'hFF00,
           16'h0FF0, 1, 0, 0);
    run_op("nota", 4'b0000, 1, 1, 16'hFFFF, 16'h1234,
           16'h0000, 1, 1, 0);
    run_op("and", 4'b1011, 1, 1, 16'hF0F0, 16'hFF00,
           16'hF000, 1, 0, 0);
    run_op("or", 4'b1110, 1, 1, 16'hF0F0, 16'hFF00,
           16'hFFF0, 1, 0, 0);

    // Backpressure then overlapped accept
    issue(4'b1001, 0, 1, 16'h1234, 16'h4321);
    tick();
    in_valid = 1'b0;
    wait_res("bp");
    issue(4'b0110, 0, 0, 16'h0007, 16'h0005);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      check_res("bp", 16'h5555, 1, 0, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("ov_in_ready", in_ready, 1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("ov_valid_low", out_valid, 0);
    check_res("ov_hold", 16'h5555, 1, 0, 0);
    wait_res("ov");
    check_res("ov", 16'h0002, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the second RUN cycle
    issue(4'b1001, 0, 1, 16'hFFFF, 16'h0001);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    check_res("mrst", 16'h0000, 1, 1, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_in_ready", in_ready, 1);
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("mrst_no_result", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
